// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite types and default widths for the AXI-lite master engine.
package axi_lite_pkg;

   localparam int AXI_AW_DEFAULT      = 32;
   localparam int AXI_DW_DEFAULT      = 32;
   localparam int AXI_TIMEOUT_DEFAULT = 256;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP,
      RSP
   } state_t;

endpackage

// File: rtl/axi_lite_ifc.sv
// AXI-lite bus bundle with master and slave views.
interface axi_lite_ifc #(
   parameter int AW = 32,
   parameter int DW = 32
);

   logic [AW-1:0]   awaddr;
   logic [2:0]      awprot;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic [2:0]      arprot;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );

endinterface

// File: rtl/axi_lite_master_engine.sv
// Single-outstanding AXI-lite initiator: turns one command into one AXI-lite
// write or read, then holds the response until the host consumes it.
module axi_lite_master_engine
   import axi_lite_pkg::*;
#(
   parameter int AW_AXI  = AXI_AW_DEFAULT,
   parameter int DW_AXI  = AXI_DW_DEFAULT,
   parameter int TIMEOUT = AXI_TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [AW_AXI-1:0]   cmd_addr,
   input  logic [DW_AXI-1:0]   cmd_wdata,
   input  logic [DW_AXI/8-1:0] cmd_wstrb,
   input  logic [2:0]          cmd_prot,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DW_AXI-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic                rsp_timeout,
   axi_lite_ifc.master         m_axi
);

   // Counter only needs to reach TIMEOUT-1; it is cleared on every accept.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t        state;
   logic [CW-1:0] tcnt;
   logic          aw_done;
   logic          w_done;

   logic          aw_hs;
   logic          w_hs;
   logic          b_hs;
   logic          ar_hs;
   logic          r_hs;
   logic          busy;
   logic          expire;
   logic          advance;
   logic          abort;

   assign aw_hs  = m_axi.awvalid & m_axi.awready;
   assign w_hs   = m_axi.wvalid  & m_axi.wready;
   assign b_hs   = m_axi.bvalid  & m_axi.bready;
   assign ar_hs  = m_axi.arvalid & m_axi.arready;
   assign r_hs   = m_axi.rvalid  & m_axi.rready;

   assign cmd_ready = (state == IDLE);
   assign busy      = state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
   assign expire    = (TIMEOUT != 0) && (tcnt == CW'(TIMEOUT - 1));

   // Decide whether the awaited handshake completes this cycle; a completing
   // handshake on the expiry cycle beats the timeout.
   always_comb begin
      // NOTE: default assigned first so every path drives advance and no latch is inferred.
      advance = 1'b0;
      case (state)
         WR_REQ:  advance = (aw_done | aw_hs) & (w_done | w_hs);
         WR_RESP: advance = b_hs;
         RD_REQ:  advance = ar_hs;
         RD_RESP: advance = r_hs;
         default: advance = 1'b0;
      endcase
   end

   assign abort = busy & expire & ~advance;

   // Engine FSM: all AXI and response outputs are registered here.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (rst) begin
         state          <= IDLE;
         tcnt           <= '0;
         aw_done        <= 1'b0;
         w_done         <= 1'b0;
         m_axi.awaddr   <= '0;
         m_axi.awprot   <= '0;
         m_axi.awvalid  <= 1'b0;
         m_axi.wdata    <= '0;
         m_axi.wstrb    <= '0;
         m_axi.wvalid   <= 1'b0;
         m_axi.bready   <= 1'b0;
         m_axi.araddr   <= '0;
         m_axi.arprot   <= '0;
         m_axi.arvalid  <= 1'b0;
         m_axi.rready   <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_rdata      <= '0;
         rsp_resp       <= '0;
         rsp_timeout    <= 1'b0;
      end else begin
         if (busy) begin
            tcnt <= tcnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  tcnt <= '0;
                  if (cmd_write) begin
                     m_axi.awaddr  <= cmd_addr;
                     m_axi.awprot  <= cmd_prot;
                     m_axi.wdata   <= cmd_wdata;
                     m_axi.wstrb   <= cmd_wstrb;
                     m_axi.awvalid <= 1'b1;
                     m_axi.wvalid  <= 1'b1;
                     aw_done       <= 1'b0;
                     w_done        <= 1'b0;
                     state         <= WR_REQ;
                  end else begin
                     m_axi.araddr  <= cmd_addr;
                     m_axi.arprot  <= cmd_prot;
                     m_axi.arvalid <= 1'b1;
                     state         <= RD_REQ;
                  end
               end
            end

            WR_REQ: begin
               // Address and data channels retire independently.
               if (aw_hs) begin
                  m_axi.awvalid <= 1'b0;
                  aw_done       <= 1'b1;
               end
               if (w_hs) begin
                  m_axi.wvalid <= 1'b0;
                  w_done       <= 1'b1;
               end
               if (advance) begin
                  m_axi.bready <= 1'b1;
                  state        <= WR_RESP;
               end
            end

            WR_RESP: begin
               if (b_hs) begin
                  m_axi.bready <= 1'b0;
                  rsp_rdata    <= '0;
                  rsp_resp     <= m_axi.bresp;
                  rsp_timeout  <= 1'b0;
                  rsp_valid    <= 1'b1;
                  state        <= RSP;
               end
            end

            RD_REQ: begin
               if (ar_hs) begin
                  m_axi.arvalid <= 1'b0;
                  m_axi.rready  <= 1'b1;
                  state         <= RD_RESP;
               end
            end

            RD_RESP: begin
               if (r_hs) begin
                  m_axi.rready <= 1'b0;
                  rsp_rdata    <= m_axi.rdata;
                  rsp_resp     <= m_axi.rresp;
                  rsp_timeout  <= 1'b0;
                  rsp_valid    <= 1'b1;
                  state        <= RSP;
               end
            end

            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase

         // Timeout overrides whatever the state branch scheduled: release the
         // bus and report a slave error flagged as a timeout.
         if (abort) begin
            m_axi.awvalid <= 1'b0;
            m_axi.wvalid  <= 1'b0;
            m_axi.arvalid <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.rready  <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= SLVERR;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
            state         <= RSP;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_master_engine.sv
// Directed bench for axi_lite_master_engine with a delay-programmable slave model.
module tb_axi_lite_master_engine;
   import axi_lite_pkg::*;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [3:0]    cmd_wstrb;
   logic [2:0]    cmd_prot;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          rsp_timeout;

   axi_lite_ifc #(.AW(AW), .DW(DW)) bus ();

   axi_lite_master_engine #(.AW_AXI(AW), .DW_AXI(DW), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_wstrb   (cmd_wstrb),
      .cmd_prot    (cmd_prot),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_resp    (rsp_resp),
      .rsp_timeout (rsp_timeout),
      .m_axi       (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave model knobs
   int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
   bit          r_never = 1'b0;
   logic [1:0]  bresp_val = 2'b00;
   logic [1:0]  rresp_val = 2'b00;
   logic [31:0] rdata_val = '0;

   int aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0;

   always @(posedge clk) begin
      if (bus.awvalid && bus.awready) aw_hs_n <= aw_hs_n + 1;
      if (bus.wvalid  && bus.wready)  w_hs_n  <= w_hs_n + 1;
      if (bus.arvalid && bus.arready) ar_hs_n <= ar_hs_n + 1;
   end

   // Slave: each ready/valid rises after its programmed number of waiting cycles.
   initial begin
      int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
      bus.bvalid = 1'b0; bus.bresp = 2'b00;
      bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.awvalid) begin
            bus.awready = (aw_cnt == aw_delay);
            if (aw_cnt < aw_delay) aw_cnt++;
         end else begin
            bus.awready = 1'b0; aw_cnt = 0;
         end
         if (bus.wvalid) begin
            bus.wready = (w_cnt == w_delay);
            if (w_cnt < w_delay) w_cnt++;
         end else begin
            bus.wready = 1'b0; w_cnt = 0;
         end
         if (bus.arvalid) begin
            bus.arready = (ar_cnt == ar_delay);
            if (ar_cnt < ar_delay) ar_cnt++;
         end else begin
            bus.arready = 1'b0; ar_cnt = 0;
         end
         if (bus.bready) begin
            bus.bvalid = (b_cnt == b_delay);
            bus.bresp  = bresp_val;
            if (b_cnt < b_delay) b_cnt++;
         end else begin
            bus.bvalid = 1'b0; b_cnt = 0;
         end
         if (bus.rready && !r_never) begin
            bus.rvalid = (r_cnt == r_delay);
            bus.rdata  = bus.rvalid ? rdata_val : '0;
            bus.rresp  = rresp_val;
            if (r_cnt < r_delay) r_cnt++;
         end else begin
            bus.rvalid = 1'b0; bus.rdata = '0; r_cnt = 0;
         end
      end
   end

   // Present a command at a negedge (cycle N); returns at the negedge of cycle N+1.
   task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [2:0] prot);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = data;
      cmd_wstrb = strb;
      cmd_prot  = prot;
      check("cmd_ready_at_accept", cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Bounded wait for rsp_valid; lat counts cycles after the accept cycle.
   task automatic wait_rsp(input int budget, output int lat);
      lat = 1;
      while (!rsp_valid && lat < budget) begin
         @(negedge clk);
         lat++;
      end
      check("rsp_valid_within_budget", rsp_valid, 1'b1);
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_valid_after_consume", rsp_valid, 1'b0);
      check("cmd_ready_after_consume", cmd_ready, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n, aw0, w0, ar0;
      bit addr_moved;
      rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; cmd_prot = '0; rsp_ready = 1'b0;

      // Reset state
      do_reset();
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_resp", rsp_resp, 2'b00);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_timeout", rsp_timeout, 1'b0);
      check("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 5'b0);
      check("rst_awaddr", bus.awaddr, 32'h0);

      // Zero-wait write: AXI valids in N+1, bready in N+2, rsp in N+3
      aw0 = aw_hs_n; w0 = w_hs_n;
      send(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 3'b010);
      check("wr0_awvalid_n1", bus.awvalid, 1'b1);
      check("wr0_wvalid_n1", bus.wvalid, 1'b1);
      check("wr0_awaddr", bus.awaddr, 32'h40);
      check("wr0_wdata", bus.wdata, 32'hDEADBEEF);
      check("wr0_wstrb", bus.wstrb, 4'hF);
      check("wr0_awprot", bus.awprot, 3'b010);
      check("wr0_bready_n1", bus.bready, 1'b0);
      @(negedge clk);
      check("wr0_bready_n2", bus.bready, 1'b1);
      check("wr0_valids_dropped_n2", {bus.awvalid, bus.wvalid}, 2'b00);
      check("wr0_rsp_valid_n2", rsp_valid, 1'b0);
      @(negedge clk);
      check("wr0_rsp_valid_n3", rsp_valid, 1'b1);
      check("wr0_rsp_resp", rsp_resp, 2'b00);
      check("wr0_rsp_rdata", rsp_rdata, 32'h0);
      check("wr0_rsp_timeout", rsp_timeout, 1'b0);
      check("wr0_bready_n3", bus.bready, 1'b0);
      check("wr0_aw_hs_count", aw_hs_n - aw0, 1);
      check("wr0_w_hs_count", w_hs_n - w0, 1);
      consume();

      // Read with arready delayed 3 cycles
      ar_delay = 3; rdata_val = 32'h12345678; rresp_val = 2'b00;
      ar0 = ar_hs_n;
      send(1'b0, 32'h0000_1004, 32'h0, 4'h0, 3'b101);
      n = 0; addr_moved = 1'b0;
      while (bus.arvalid && n < 20) begin
         if (bus.araddr !== 32'h0000_1004 || bus.arprot !== 3'b101) addr_moved = 1'b1;
         n++;
         @(negedge clk);
      end
      check("rd_arvalid_cycles", n, 4);
      check("rd_ar_payload_stable", addr_moved, 1'b0);
      check("rd_ar_hs_count", ar_hs_n - ar0, 1);
      wait_rsp(20, lat);
      check("rd_rsp_rdata", rsp_rdata, 32'h12345678);
      check("rd_rsp_resp", rsp_resp, 2'b00);
      check("rd_rsp_timeout", rsp_timeout, 1'b0);
      consume();
      ar_delay = 0;

      // Write with wready two cycles before awready
      aw_delay = 2; w_delay = 0;
      aw0 = aw_hs_n; w0 = w_hs_n;
      send(1'b1, 32'h80, 32'h0BAD_F00D, 4'h3, 3'b000);
      check("wsplit_both_valid_n1", {bus.awvalid, bus.wvalid}, 2'b11);
      @(negedge clk);
      check("wsplit_w_first_n2", {bus.awvalid, bus.wvalid}, 2'b10);
      check("wsplit_bready_n2", bus.bready, 1'b0);
      @(negedge clk);
      check("wsplit_aw_held_n3", {bus.awvalid, bus.wvalid}, 2'b10);
      check("wsplit_bready_n3", bus.bready, 1'b0);
      @(negedge clk);
      check("wsplit_aw_done_n4", bus.awvalid, 1'b0);
      check("wsplit_bready_n4", bus.bready, 1'b1);
      wait_rsp(20, lat);
      check("wsplit_rsp_resp", rsp_resp, 2'b00);
      check("wsplit_aw_hs_count", aw_hs_n - aw0, 1);
      check("wsplit_w_hs_count", w_hs_n - w0, 1);
      consume();
      aw_delay = 0;

      // DECERR write response held while rsp_ready stays low
      bresp_val = 2'b11;
      send(1'b1, 32'hC0, 32'h5555_AAAA, 4'hF, 3'b000);
      wait_rsp(20, lat);
      check("decerr_latency", lat, 3);
      for (int i = 0; i < 5; i++) begin
         check("decerr_rsp_valid_held", rsp_valid, 1'b1);
         check("decerr_rsp_resp_held", rsp_resp, 2'b11);
         check("decerr_cmd_ready_low", cmd_ready, 1'b0);
         @(negedge clk);
      end
      consume();
      bresp_val = 2'b00;

      // rvalid lands exactly on the expiry cycle: normal response wins
      r_delay = 14; rdata_val = 32'hCAFEF00D; rresp_val = 2'b01;
      send(1'b0, 32'h200, 32'h0, 4'h0, 3'b000);
      wait_rsp(40, lat);
      check("expiry_hs_latency", lat, 17);
      check("expiry_hs_timeout", rsp_timeout, 1'b0);
      check("expiry_hs_resp", rsp_resp, 2'b01);
      check("expiry_hs_rdata", rsp_rdata, 32'hCAFEF00D);
      consume();
      r_delay = 0; rresp_val = 2'b00;

      // Slave never answers the read: timeout after 16 cycles
      r_never = 1'b1;
      send(1'b0, 32'h300, 32'h0, 4'h0, 3'b000);
      repeat (15) @(negedge clk);
      check("tmo_rready_before_expiry", bus.rready, 1'b1);
      check("tmo_no_rsp_before_expiry", rsp_valid, 1'b0);
      @(negedge clk);
      check("tmo_rsp_valid", rsp_valid, 1'b1);
      check("tmo_rsp_timeout", rsp_timeout, 1'b1);
      check("tmo_rsp_resp", rsp_resp, 2'b10);
      check("tmo_rsp_rdata", rsp_rdata, 32'h0);
      check("tmo_rready_dropped", bus.rready, 1'b0);
      consume();
      r_never = 1'b0;
      do_reset();

      // Reset pulsed while in WR_REQ aborts without completion
      aw_delay = 10; w_delay = 10;
      send(1'b1, 32'h400, 32'h1111_2222, 4'hF, 3'b000);
      check("rstmid_in_wr_req", {bus.awvalid, bus.wvalid}, 2'b11);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstmid_valids", {bus.awvalid, bus.wvalid}, 2'b00);
      check("rstmid_rsp_valid", rsp_valid, 1'b0);
      check("rstmid_cmd_ready", cmd_ready, 1'b1);
      aw_delay = 0; w_delay = 0;

      // Engine operates normally after the abort
      send(1'b1, 32'h44, 32'h0000_0001, 4'h1, 3'b000);
      wait_rsp(20, lat);
      check("post_rst_latency", lat, 3);
      check("post_rst_resp", rsp_resp, 2'b00);
      consume();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
